// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the program-counter sequencer.
//   state_t     : sequencer state encoding (IDLE, RUN, HALTED)
//   CAUSE_*     : values reported on halt_cause
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_NONE = 2'd0;  // not halted / freshly started
    localparam logic [1:0] CAUSE_ADDR = 2'd1;  // next PC matched halt_addr
    localparam logic [1:0] CAUSE_SELF = 2'd2;  // jump to the current PC
    localparam logic [1:0] CAUSE_END  = 2'd3;  // ran off the top of memory

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones instead of wrapping.
//   clk : rising-edge clock
//   rst : synchronous active-high reset to 0
//   clr : synchronous clear to 0 (same effect as rst, used for restarts)
//   inc : count up by one this edge unless already saturated
//   q   : current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE = W'(1);
    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc && (q != MAX)) begin
            q <= q + ONE;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with stall, jump and hardware
// completion detection (halt address, self-jump, end of memory).
//   clk, rst       : clock and synchronous active-high reset
//   start          : leave IDLE, or restart from HALTED
//   stall          : hold the PC this cycle (RUN only)
//   jump_valid     : load jump_addr instead of incrementing (RUN only)
//   jump_addr      : jump target
//   halt_en        : enable halt-address detection
//   halt_addr      : address whose arrival halts the sequencer
//   pc             : current PC (registered)
//   running        : state is RUN
//   halted         : state is HALTED
//   halt_cause     : CAUSE_NONE / CAUSE_ADDR / CAUSE_SELF / CAUSE_END
//   cycle_count    : cycles spent in RUN (saturating)
//   retired_count  : RUN cycles without stall (saturating)
//
// Handshake: there is no valid/ready pair here; start, stall and jump_valid
// are level-sampled on every rising edge and act only in the states that
// use them.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W   = 4,
    parameter int                CNT_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter bit                WRAP     = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              halt_en,
    input  logic [ADDR_W-1:0] halt_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              running,
    output logic              halted,
    output logic [1:0]        halt_cause,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  retired_count
);

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PC_MAX = '1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [1:0]        cause_nxt;
    logic              cyc_inc, ret_inc, cnt_clr;
    logic [ADDR_W-1:0] cand_pc;   // computed next PC for jump / increment
    logic              at_end;    // increment would run off the top of memory

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            halt_cause <= CAUSE_NONE;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            halt_cause <= cause_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cause_nxt = halt_cause;
        cyc_inc   = 1'b0;
        ret_inc   = 1'b0;
        cnt_clr   = 1'b0;
        cand_pc   = pc;
        at_end    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                cyc_inc = 1'b1;
                if (!stall) begin
                    // The halting edge still retires the current instruction.
                    ret_inc = 1'b1;
                    if (jump_valid && (jump_addr == pc)) begin
                        state_nxt = ST_HALTED;
                        cause_nxt = CAUSE_SELF;
                    end else begin
                        if (jump_valid) begin
                            cand_pc = jump_addr;
                        end else if (pc == PC_MAX) begin
                            cand_pc = '0;
                            at_end  = !WRAP;
                        end else begin
                            cand_pc = pc + PC_ONE;
                        end

                        if (at_end) begin
                            state_nxt = ST_HALTED;
                            cause_nxt = CAUSE_END;
                        end else begin
                            pc_nxt = cand_pc;
                            // Only a computed next PC can match, so a
                            // halt_addr equal to RESET_PC never fires on start.
                            if (halt_en && (cand_pc == halt_addr)) begin
                                state_nxt = ST_HALTED;
                                cause_nxt = CAUSE_ADDR;
                            end
                        end
                    end
                end
            end

            ST_HALTED: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    pc_nxt    = RESET_PC;
                    cause_nxt = CAUSE_NONE;
                    cnt_clr   = 1'b1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                pc_nxt    = RESET_PC;
                cause_nxt = CAUSE_NONE;
            end
        endcase
    end

    assign running = (state == ST_RUN);
    assign halted  = (state == ST_HALTED);

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cyc_inc),
        .q   (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_retired_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (ret_inc),
        .q   (retired_count)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: two sequencer instances (WRAP=0 with 16-bit counters,
// WRAP=1 with 4-bit counters so saturation is reached) share one stimulus
// stream. A behavioural model tracks each instance and is compared every
// cycle; directed sections pin the model with hand-computed literals.
module tb_pc_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic       jump_valid = 1'b0;
    logic [3:0] jump_addr = 4'd0;
    logic       halt_en = 1'b0;
    logic [3:0] halt_addr = 4'd0;

    logic [3:0]  pc0, pc1;
    logic        run0, run1, hlt0, hlt1;
    logic [1:0]  cause0, cause1;
    logic [15:0] cyc0, ret0;
    logic [3:0]  cyc1, ret1;

    pc_sequencer #(.ADDR_W(4), .CNT_W(16), .RESET_PC(4'd0), .WRAP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .jump_valid(jump_valid), .jump_addr(jump_addr),
        .halt_en(halt_en), .halt_addr(halt_addr),
        .pc(pc0), .running(run0), .halted(hlt0), .halt_cause(cause0),
        .cycle_count(cyc0), .retired_count(ret0)
    );

    pc_sequencer #(.ADDR_W(4), .CNT_W(4), .RESET_PC(4'd0), .WRAP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .jump_valid(jump_valid), .jump_addr(jump_addr),
        .halt_en(halt_en), .halt_addr(halt_addr),
        .pc(pc1), .running(run1), .halted(hlt1), .halt_cause(cause1),
        .cycle_count(cyc1), .retired_count(ret1)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 run, 2 halted
    int  m_mode[2];
    int  m_pc[2];
    int  m_cause[2];
    int  m_cyc[2];
    int  m_ret[2];
    bit  model_ok = 1'b0;

    task automatic model_step(input int k);
        int cmax;
        int wrap;
        int nxt;
        cmax = (k == 0) ? 65535 : 15;
        wrap = (k == 0) ? 0 : 1;
        if (rst) begin
            m_mode[k] = 0; m_pc[k] = 0; m_cause[k] = 0; m_cyc[k] = 0; m_ret[k] = 0;
        end else if (m_mode[k] == 0) begin
            if (start) m_mode[k] = 1;
        end else if (m_mode[k] == 2) begin
            if (start) begin
                m_mode[k] = 1; m_pc[k] = 0; m_cause[k] = 0; m_cyc[k] = 0; m_ret[k] = 0;
            end
        end else begin
            if (m_cyc[k] < cmax) m_cyc[k] = m_cyc[k] + 1;
            if (!stall) begin
                if (m_ret[k] < cmax) m_ret[k] = m_ret[k] + 1;
                if (jump_valid && int'(jump_addr) == m_pc[k]) begin
                    m_mode[k] = 2; m_cause[k] = 2;
                end else if (!jump_valid && m_pc[k] == 15 && wrap == 0) begin
                    m_mode[k] = 2; m_cause[k] = 3;
                end else begin
                    nxt = jump_valid ? int'(jump_addr) : (m_pc[k] + 1) % 16;
                    m_pc[k] = nxt;
                    if (halt_en && nxt == int'(halt_addr)) begin
                        m_mode[k] = 2; m_cause[k] = 1;
                    end
                end
            end
        end
    endtask

    // Compare process: update the model from the inputs sampled at the
    // edge, then check every output 1 time unit later.
    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        if (rst) model_ok = 1'b1;
        #1;
        if (model_ok) begin
            check("d0_pc",      int'(pc0),    m_pc[0]);
            check("d0_running", int'(run0),   int'(m_mode[0] == 1));
            check("d0_halted",  int'(hlt0),   int'(m_mode[0] == 2));
            check("d0_cause",   int'(cause0), m_cause[0]);
            check("d0_cycles",  int'(cyc0),   m_cyc[0]);
            check("d0_retired", int'(ret0),   m_ret[0]);
            check("d1_pc",      int'(pc1),    m_pc[1]);
            check("d1_running", int'(run1),   int'(m_mode[1] == 1));
            check("d1_halted",  int'(hlt1),   int'(m_mode[1] == 2));
            check("d1_cause",   int'(cause1), m_cause[1]);
            check("d1_cycles",  int'(cyc1),   m_cyc[1]);
            check("d1_retired", int'(ret1),   m_ret[1]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_inputs();
        start = 1'b0; stall = 1'b0; jump_valid = 1'b0; jump_addr = 4'd0;
        halt_en = 1'b0; halt_addr = 4'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cycles(1);
        start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        cycles(1);
        do_reset();

        // Reset state
        check("lit_reset_pc", int'(pc0), 0);
        check("lit_reset_running", int'(run0), 0);
        check("lit_reset_halted", int'(hlt0), 0);
        check("lit_reset_cause", int'(cause0), 0);
        check("lit_reset_cycles", int'(cyc0), 0);
        check("lit_reset_retired", int'(ret0), 0);

        // start does not move pc; then 3 free-running edges
        do_start();
        check("lit_start_pc", int'(pc0), 0);
        check("lit_start_running", int'(run0), 1);
        cycles(3);
        check("lit_free_pc", int'(pc0), 3);
        check("lit_free_retired", int'(ret0), 3);

        // Halt-address match at 3
        do_reset();
        halt_en = 1'b1; halt_addr = 4'd3;
        do_start();
        cycles(3);
        check("lit_haddr_halted", int'(hlt0), 1);
        check("lit_haddr_pc", int'(pc0), 3);
        check("lit_haddr_cause", int'(cause0), 1);
        check("lit_haddr_retired", int'(ret0), 3);
        cycles(5);
        check("lit_haddr_hold_pc", int'(pc0), 3);
        check("lit_haddr_hold_cycles", int'(cyc0), 3);

        // Jump to 0xA at pc=2, then self-jump at 0xB
        do_reset();
        do_start();
        cycles(2);
        check("lit_jmp_pre_pc", int'(pc0), 2);
        jump_valid = 1'b1; jump_addr = 4'hA;
        cycles(1);
        jump_valid = 1'b0;
        check("lit_jmp_pc", int'(pc0), 10);
        cycles(1);
        check("lit_jmp_next_pc", int'(pc0), 11);
        jump_valid = 1'b1; jump_addr = 4'hB;
        cycles(1);
        jump_valid = 1'b0;
        check("lit_self_halted", int'(hlt0), 1);
        check("lit_self_cause", int'(cause0), 2);
        check("lit_self_pc", int'(pc0), 11);

        // Stall 4 cycles at pc=5, then run to the top of memory
        do_reset();
        do_start();
        cycles(5);
        stall = 1'b1;
        cycles(4);
        stall = 1'b0;
        check("lit_stall_pc", int'(pc0), 5);
        check("lit_stall_cycles", int'(cyc0), 9);
        check("lit_stall_retired", int'(ret0), 5);
        cycles(10);
        check("lit_top_pc", int'(pc0), 15);
        cycles(1);
        check("lit_end_halted", int'(hlt0), 1);
        check("lit_end_cause", int'(cause0), 3);
        check("lit_end_pc", int'(pc0), 15);
        check("lit_end_retired", int'(ret0), 16);
        check("lit_wrap_pc", int'(pc1), 0);
        check("lit_wrap_running", int'(run1), 1);
        check("lit_wrap_cycles_sat", int'(cyc1), 15);

        // Restart from HALTED
        do_start();
        check("lit_restart_running", int'(run0), 1);
        check("lit_restart_pc", int'(pc0), 0);
        check("lit_restart_cause", int'(cause0), 0);
        check("lit_restart_cycles", int'(cyc0), 0);

        // Reset while stalled at pc=7
        do_reset();
        do_start();
        cycles(7);
        stall = 1'b1;
        cycles(2);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0; stall = 1'b0;
        check("lit_rst_stall_pc", int'(pc0), 0);
        check("lit_rst_stall_running", int'(run0), 0);
        check("lit_rst_stall_cycles", int'(cyc0), 0);
        check("lit_rst_stall_retired", int'(ret0), 0);

        // Randomized phase, checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            start      = ($urandom_range(0, 7) == 0);
            stall      = ($urandom_range(0, 3) == 0);
            jump_valid = ($urandom_range(0, 5) == 0);
            jump_addr  = 4'($urandom_range(0, 15));
            halt_en    = ($urandom_range(0, 3) == 0);
            halt_addr  = 4'($urandom_range(0, 15));
            cycles(1);
        end
        idle_inputs();
        cycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
